// File: rtl/l0_ctrl_pkg.sv
// Shared constants for the L0 job sequencer: bank geometry, counter width,
// FSM state encoding and the job-length legality rule.
package l0_ctrl_pkg;

    localparam int L0_ROW   = 8;
    localparam int L0_DEPTH = 64;
    localparam int L0_CNT_W = 7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // A job must carry at least one vector and must fit in one row FIFO.
    function automatic logic len_ok(input logic [L0_CNT_W-1:0] len);
        return (len != '0) && (len <= L0_CNT_W'(L0_DEPTH));
    endfunction

endpackage

// File: rtl/l0_seq_ctrl_if.sv
// Job/source/L0 handshake bundle between the activation source side and the
// sequencer; master drives requests and L0 status, slave is the sequencer.
interface l0_seq_ctrl_if
    import l0_ctrl_pkg::*;
();

    logic                start;
    logic [L0_CNT_W-1:0] len;
    logic                src_valid;
    logic                src_ready;
    logic                l0_full;
    logic                l0_ready;
    logic                l0_wr;
    logic                l0_rd;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, len, src_valid, l0_full, l0_ready,
        input  src_ready, l0_wr, l0_rd, busy, done, err
    );

    modport slave (
        input  start, len, src_valid, l0_full, l0_ready,
        output src_ready, l0_wr, l0_rd, busy, done, err
    );

endinterface

// File: rtl/l0_job_cnt.sv
// Clear/enable up-counter with a terminal-match flag; one instance per job
// phase (write, read, flush).
module l0_job_cnt
    import l0_ctrl_pkg::*;
#(
    parameter int W = L0_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] target,
    output logic         match
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match = (cnt == target);

endmodule

// File: rtl/l0_seq_ctrl.sv
// Job sequencer for the row-staggered L0 FIFO bank: LOAD len vectors, DRAIN
// len back-to-back reads, FLUSH the row skew, then pulse done.
module l0_seq_ctrl
    import l0_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    l0_seq_ctrl_if.slave bus
);

    localparam logic [L0_CNT_W-1:0] FL_LAST = L0_CNT_W'(L0_ROW - 1);

    logic [2:0]          state;
    logic [L0_CNT_W-1:0] len_q;
    logic                rd_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic cnt_clr;
    logic wr_en, rd_en, fl_en;
    logic wr_match, rd_match, fl_match;
    logic wr_last, rd_last, fl_last;

    // The write strobe is the only combinational output: it must track the
    // source and bank flags in the same cycle so no write lands on a full row.
    assign wr_en = (state == ST_LOAD) & bus.src_valid & bus.l0_ready & ~bus.l0_full;
    assign rd_en = rd_q;
    assign fl_en = (state == ST_FLUSH);

    assign cnt_clr = (state == ST_IDLE);
    assign wr_last = wr_en & wr_match;
    assign rd_last = rd_en & rd_match;
    assign fl_last = fl_en & fl_match;

    l0_job_cnt #(.W(L0_CNT_W)) u_wr_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (wr_en),
        .target (len_q - 1'b1),
        .match  (wr_match)
    );

    l0_job_cnt #(.W(L0_CNT_W)) u_rd_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (rd_en),
        .target (len_q - 1'b1),
        .match  (rd_match)
    );

    l0_job_cnt #(.W(L0_CNT_W)) u_fl_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (fl_en),
        .target (FL_LAST),
        .match  (fl_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            rd_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (len_ok(bus.len)) begin
                            len_q  <= bus.len;
                            state  <= ST_LOAD;
                            busy_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Raising rd here makes the first DRAIN cycle the first read.
                    if (wr_last) begin
                        state <= ST_DRAIN;
                        rd_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (rd_last) begin
                        state <= ST_FLUSH;
                        rd_q  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (fl_last) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    rd_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.l0_wr     = wr_en;
    assign bus.src_ready = wr_en;
    assign bus.l0_rd     = rd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_l0_seq_ctrl.sv
// Self-checking bench for l0_seq_ctrl: a cycle-schedule reference model plus
// a queue model of the skewed L0 row FIFO bank.
module tb_l0_seq_ctrl;
    import l0_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l0_seq_ctrl_if bus ();

    l0_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference schedule: absolute cycle numbers derived from the job rules.
    bit job_on   = 1'b0;
    int t_start  = 0;
    int t_last   = -1;
    int t_err    = -10;
    int job_len  = 0;
    int loaded   = 0;
    int idle_cyc = 0;

    int wr_total = 0;
    int rd_total = 0;
    int err_seen = 0;
    int done_cyc = 0;
    int max_occ  = 0;
    int src_idx  = 0;

    logic force_full = 1'b0;
    int row_exp [L0_ROW];
    int rowq    [L0_ROW][$];
    logic [L0_ROW-1:0] rd_pipe = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic st, input int ln, input logic sv);
        bus.start     = st;
        bus.len       = L0_CNT_W'(ln);
        bus.src_valid = sv;
    endtask

    // One clock: entered and left at a negedge with inputs already driven.
    task automatic cycle();
        logic any_full;
        logic a_wr, a_srdy, a_rd, a_done, a_err, a_busy;
        logic e_wr, e_rd, e_done, e_err, e_busy;
        int   v;

        any_full = 1'b0;
        for (int i = 0; i < L0_ROW; i++)
            if (rowq[i].size() >= L0_DEPTH) any_full = 1'b1;
        bus.l0_full  = force_full | any_full;
        bus.l0_ready = ~any_full;
        #1;

        e_busy = job_on && (cyc > t_start);
        e_wr   = e_busy && (loaded < job_len) && bus.src_valid && !bus.l0_full && bus.l0_ready;
        e_rd   = job_on && (t_last >= 0) && (cyc > t_last) && (cyc <= t_last + job_len);
        e_done = job_on && (t_last >= 0) && (cyc == t_last + job_len + L0_ROW + 1);
        e_err  = (cyc == t_err + 1);

        a_wr   = bus.l0_wr;
        a_srdy = bus.src_ready;
        a_rd   = bus.l0_rd;
        a_done = bus.done;
        a_err  = bus.err;
        a_busy = bus.busy;

        if (!reset) begin
            check("l0_wr",     32'(a_wr),   32'(e_wr));
            check("src_ready", 32'(a_srdy), 32'(e_wr));
            check("l0_rd",     32'(a_rd),   32'(e_rd));
            check("done",      32'(a_done), 32'(e_done));
            check("err",       32'(a_err),  32'(e_err));
            check("busy",      32'(a_busy), 32'(e_busy));
        end

        @(posedge clk);
        if (reset) begin
            job_on  = 1'b0;
            t_err   = -10;
            t_last  = -1;
            rd_pipe = '0;
            for (int i = 0; i < L0_ROW; i++) rowq[i].delete();
        end else begin
            // Bank model: rows pop on their skewed read, then the shared write lands.
            for (int i = 0; i < L0_ROW; i++) begin
                if (rd_pipe[i]) begin
                    check("row_pop_nonempty", 32'(rowq[i].size() != 0), 32'd1);
                    if (rowq[i].size() != 0) begin
                        v = rowq[i].pop_front();
                        check("row_order", 32'(v), 32'(row_exp[i]));
                        row_exp[i]++;
                    end
                end
            end
            rd_pipe = {rd_pipe[L0_ROW-2:0], a_rd};
            if (a_wr) begin
                for (int i = 0; i < L0_ROW; i++) rowq[i].push_back(src_idx);
                src_idx++;
                wr_total++;
                if (rowq[L0_ROW-1].size() > max_occ) max_occ = rowq[L0_ROW-1].size();
            end
            if (a_rd)   rd_total++;
            if (a_err)  err_seen++;
            if (a_done) done_cyc = cyc;

            if (e_wr) begin
                loaded++;
                if (loaded == job_len) t_last = cyc;
            end
            if (e_done) begin
                job_on   = 1'b0;
                idle_cyc = cyc + 1;
            end
            if (!e_busy && bus.start) begin
                if (bus.len >= 1 && int'(bus.len) <= L0_DEPTH) begin
                    job_on   = 1'b1;
                    t_start  = cyc;
                    t_last   = -1;
                    job_len  = int'(bus.len);
                    loaded   = 0;
                    wr_total = 0;
                    rd_total = 0;
                    max_occ  = 0;
                    src_idx  = 0;
                    for (int i = 0; i < L0_ROW; i++) row_exp[i] = 0;
                end else begin
                    t_err = cyc;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // mode 0: src always valid; 1: toggling; 2: random valid/full/stray starts.
    task automatic run_to_idle(input int mode, input int budget);
        int n;
        n = 0;
        while (job_on && n < budget) begin
            bus.start = 1'b0;
            force_full = 1'b0;
            case (mode)
                0: bus.src_valid = 1'b1;
                1: bus.src_valid = (cyc % 2 == 0);
                default: begin
                    bus.src_valid = ($urandom_range(0, 3) != 0);
                    force_full    = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 9) == 0) begin
                        bus.start = 1'b1;
                        bus.len   = L0_CNT_W'($urandom_range(0, 70));
                    end
                end
            endcase
            cycle();
            n++;
        end
        bus.start  = 1'b0;
        force_full = 1'b0;
        check("job_end_within_bound", 32'(job_on), 32'd0);
    endtask

    initial begin
        int n;
        int ln;

        // Reset, then idle.
        drive(1'b0, 0, 1'b0);
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (5) cycle();
        check("idle_no_writes", 32'(wr_total), 32'd0);

        // Short job, source always valid: exact latency.
        drive(1'b1, 4, 1'b1);
        cycle();
        run_to_idle(0, 100);
        check("len4_writes", 32'(wr_total), 32'd4);
        check("len4_reads", 32'(rd_total), 32'd4);
        check("len4_done_lat", 32'(done_cyc - t_start), 32'(1 + 4 + 4 + L0_ROW));
        check("len4_idle_lat", 32'(idle_cyc - t_start), 32'(1 + 4 + 4 + L0_ROW + 1));

        // Full-depth job with toggling source.
        drive(1'b1, L0_DEPTH, 1'b1);
        cycle();
        run_to_idle(1, 600);
        check("len64_writes", 32'(wr_total), 32'(L0_DEPTH));
        check("len64_reads", 32'(rd_total), 32'(L0_DEPTH));
        check("len64_peak_occ", 32'(max_occ), 32'(L0_DEPTH));

        // Illegal lengths.
        n = err_seen;
        drive(1'b1, 0, 1'b1);
        cycle();
        drive(1'b0, 0, 1'b1);
        cycle();
        drive(1'b1, L0_DEPTH + 1, 1'b1);
        cycle();
        drive(1'b0, 0, 1'b1);
        repeat (3) cycle();
        check("illegal_len_errs", 32'(err_seen - n), 32'd2);

        // Reset in DRAIN after two read pulses, then a clean job.
        drive(1'b1, 6, 1'b1);
        cycle();
        drive(1'b0, 0, 1'b1);
        n = 0;
        while (!(t_last >= 0 && cyc == t_last + 3) && n < 50) begin
            cycle();
            n++;
        end
        check("reach_drain_bound", 32'(n < 50), 32'd1);
        check("reads_before_reset", 32'(rd_total), 32'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n = done_cyc;
        repeat (20) cycle();
        check("no_done_after_abort", 32'(done_cyc), 32'(n));
        drive(1'b1, 3, 1'b1);
        cycle();
        run_to_idle(0, 100);
        check("len3_writes", 32'(wr_total), 32'd3);
        check("len3_reads", 32'(rd_total), 32'd3);

        // Full stall for 10 cycles mid-LOAD, with a stray start while busy.
        drive(1'b1, 10, 1'b1);
        cycle();
        drive(1'b0, 0, 1'b1);
        repeat (3) cycle();
        force_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(i == 4, 5, 1'b1);
            cycle();
        end
        force_full = 1'b0;
        bus.start  = 1'b0;
        run_to_idle(0, 200);
        check("stall_writes", 32'(wr_total), 32'd10);
        check("stall_reads", 32'(rd_total), 32'd10);
        check("stall_done_lat", 32'(done_cyc - t_start), 32'(1 + 10 + 10 + L0_ROW + 10));

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            ln = (j == 5) ? L0_DEPTH : int'($urandom_range(1, 24));
            drive(1'b1, ln, 1'b1);
            cycle();
            run_to_idle(2, 3000);
            check("rand_writes", 32'(wr_total), 32'(ln));
            check("rand_reads", 32'(rd_total), 32'(ln));
            drive(1'b0, 0, 1'b0);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
